z80_regfile_banked: RTL and testbench
=====================================

Name: z80_regfile_banked

Overview:
Parametrised successor to the single-bank Z80 register file. Holds the main and shadow (primed) register sets, the index registers IX/IY, PC and SP. Supports EXX, EX AF,AF' and EX DE,HL exchanges, PC increment and SP push/pop adjust, alongside the existing 8-bit, 16-bit and flag write ports. Sits between the decoder/ALU and the bus interface; all outputs are registered and reflect the active bank.

Parameters:
SP_RESET, 16'hFFFE, SP value after reset
PC_RESET, 16'h0000, PC value after reset
ENABLE_SHADOW, 1, 0: exx/ex_af ignored, shadow set not built
ENABLE_INDEX, 1, 0: IX/IY outputs tied 0, writes to them ignored

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
reg8_we  in  1  8-bit write enable
reg8_dst  in  3  0=A 1=B 2=C 3=D 4=E 5=H 6=L 7=F
reg8_data  in  8  8-bit write data
reg16_we  in  1  16-bit write enable
reg16_dst  in  3  0=BC 1=DE 2=HL 3=SP 4=PC 5=IX 6=IY 7=AF
reg16_data  in  16  16-bit write data (high byte to first-named reg)
flags_we  in  1  flag write enable
flags  in  8  flag data to F
exx  in  1  swap BC/DE/HL with shadow set
ex_af  in  1  swap AF with AF'
ex_de_hl  in  1  swap DE and HL in active set
pc_inc  in  1  PC <= PC+1
sp_op  in  2  00 none, 01 SP-2, 10 SP+2, 11 none (reserved)
A,B,C,D,E,H,L,F  out  8 each  active-bank registers
IX,IY,PC,SP  out  16 each  index, program counter, stack pointer

Behaviour:
- Reset (clk edge with reset=1): all main and shadow regs 0, IX=IY=0, PC=PC_RESET, SP=SP_RESET, both bank-select bits 0. Reset overrides every other input in that cycle.
- Storage model: two physical sets. af_sel selects the active AF; gp_sel selects the active BC/DE/HL. exx toggles gp_sel; ex_af toggles af_sel. Outputs always show the set selected after the edge.
- All updates take effect at the rising edge. Outputs are valid 1 cycle after inputs are sampled. No combinational input-to-output path.
- Writes address the bank that is active at the start of the cycle. If exx/ex_af toggles in the same cycle, the written value lands in the now-shadow register.
- ex_de_hl swaps D<->H and E<->L in the pre-exx active set. It is allowed together with exx: the swap applies to the old set, then the bank toggles.
- Write priority per physical register: reg16 > reg8 > flags > exchange move. Example: reg8 D=55 with ex_de_hl gives D=55, H=old D.
- flags_we and reg8 to F in the same cycle: reg8 wins.
- reg16 to PC overrides pc_inc.
- reg16 to SP overrides sp_op.
- reg16 to AF writes A=data[15:8], F=data[7:0] and overrides reg8/flags writes to A/F.
- Arithmetic is modulo 2^16.
  - PC FFFF+1 -> 0000.
  - SP 0001 with 01 -> FFFF.
  - SP FFFE with 10 -> 0000.
- ENABLE_SHADOW=0: exx/ex_af have no effect; ex_de_hl still works.
- ENABLE_INDEX=0: reg16_dst 5/6 writes are dropped.
- Reset asserted mid-sequence: the next cycle shows reset values regardless of pending exchanges.

Test Plan:
- Reset, then write 16-bit BC=ABCD, DE=1234, HL=5678. Pulse exx -> BC=DE=HL=0. Pulse exx again -> BC=ABCD, DE=1234, HL=5678.
- Write AF=12F0, pulse ex_af -> A=00, F=00. Write A=77 -> A=77. Pulse ex_af -> A=12, F=F0.
- DE=1234, HL=5678, then ex_de_hl plus reg8 D=55 in the same cycle -> D=55, E=78, H=12, L=34.
- Write PC=FFFF, pc_inc -> PC=0000. Write SP=0001, sp_op=01 -> SP=FFFF. Then sp_op=10 -> SP=0001. sp_op=01 together with reg16 SP=8000 -> SP=8000.
- Write B=11 together with exx -> B=00 (active). Then exx -> B=11.
- Same-cycle flags_we=F0 and reg8 F=0F -> F=0F. Then reset during exx -> all regs 0, SP=FFFE, PC=0000, main bank selected.

Source files
------------

// File: rtl/z80_regfile_banked.sv
// Z80 register file with main/shadow banks, IX/IY, PC and SP.
//
// Two physical 8-register sets (A,B,C,D,E,H,L,F). af_sel_q picks the active A/F pair,
// gp_sel_q the active B..L group. EXX toggles gp_sel_q, EX AF,AF' toggles af_sel_q,
// EX DE,HL swaps D<->H and E<->L inside the group active at the start of the cycle.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   reg8_we_i/dst_i/data_i    8-bit write (0=A 1=B 2=C 3=D 4=E 5=H 6=L 7=F)
//   reg16_we_i/dst_i/data_i   16-bit write (0=BC 1=DE 2=HL 3=SP 4=PC 5=IX 6=IY 7=AF)
//   flags_we_i, flags_i       flag write to F
//   exx_i, ex_af_i, ex_de_hl_i exchanges
//   pc_inc_i                  PC increment
//   sp_op_i                   00 none, 01 SP-2, 10 SP+2, 11 none
//   a_o..f_o, ix_o, iy_o, pc_o, sp_o  active-bank register values
module z80_regfile_banked #(
  parameter logic [15:0] SP_RESET      = 16'hFFFE,
  parameter logic [15:0] PC_RESET      = 16'h0000,
  parameter bit          ENABLE_SHADOW = 1'b1,
  parameter bit          ENABLE_INDEX  = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        reg8_we_i,
  input  logic [2:0]  reg8_dst_i,
  input  logic [7:0]  reg8_data_i,
  input  logic        reg16_we_i,
  input  logic [2:0]  reg16_dst_i,
  input  logic [15:0] reg16_data_i,
  input  logic        flags_we_i,
  input  logic [7:0]  flags_i,
  input  logic        exx_i,
  input  logic        ex_af_i,
  input  logic        ex_de_hl_i,
  input  logic        pc_inc_i,
  input  logic [1:0]  sp_op_i,
  output logic [7:0]  a_o,
  output logic [7:0]  b_o,
  output logic [7:0]  c_o,
  output logic [7:0]  d_o,
  output logic [7:0]  e_o,
  output logic [7:0]  h_o,
  output logic [7:0]  l_o,
  output logic [7:0]  f_o,
  output logic [15:0] ix_o,
  output logic [15:0] iy_o,
  output logic [15:0] pc_o,
  output logic [15:0] sp_o
);

  localparam int unsigned IdxA = 0;
  localparam int unsigned IdxB = 1;
  localparam int unsigned IdxC = 2;
  localparam int unsigned IdxD = 3;
  localparam int unsigned IdxE = 4;
  localparam int unsigned IdxH = 5;
  localparam int unsigned IdxL = 6;
  localparam int unsigned IdxF = 7;

  // With ENABLE_SHADOW=0 the select bits never leave 0, so bank 1 is unreachable and pruned.
  logic [7:0]  rf_q [2][8];
  logic [7:0]  rf_d [2][8];
  logic [15:0] ix_q, ix_d, iy_q, iy_d, pc_q, pc_d, sp_q, sp_d;
  logic        af_sel_q, af_sel_d, gp_sel_q, gp_sel_d;
  logic        w8_bank;

  // A and F follow the AF select; everything else follows the general-purpose select.
  assign w8_bank = ((reg8_dst_i == 3'd0) || (reg8_dst_i == 3'd7)) ? af_sel_q : gp_sel_q;

  // Later assignments win: exchange < flags < reg8 < reg16.
  always_comb begin
    rf_d     = rf_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    af_sel_d = af_sel_q;
    gp_sel_d = gp_sel_q;

    if (ex_de_hl_i) begin
      rf_d[gp_sel_q][IdxD] = rf_q[gp_sel_q][IdxH];
      rf_d[gp_sel_q][IdxH] = rf_q[gp_sel_q][IdxD];
      rf_d[gp_sel_q][IdxE] = rf_q[gp_sel_q][IdxL];
      rf_d[gp_sel_q][IdxL] = rf_q[gp_sel_q][IdxE];
    end

    if (flags_we_i) rf_d[af_sel_q][IdxF] = flags_i;
    if (reg8_we_i)  rf_d[w8_bank][reg8_dst_i] = reg8_data_i;

    if (pc_inc_i) pc_d = pc_q + 16'd1;
    unique case (sp_op_i)
      2'b01:   sp_d = sp_q - 16'd2;
      2'b10:   sp_d = sp_q + 16'd2;
      default: ;
    endcase

    if (reg16_we_i) begin
      unique case (reg16_dst_i)
        3'd0: begin
          rf_d[gp_sel_q][IdxB] = reg16_data_i[15:8];
          rf_d[gp_sel_q][IdxC] = reg16_data_i[7:0];
        end
        3'd1: begin
          rf_d[gp_sel_q][IdxD] = reg16_data_i[15:8];
          rf_d[gp_sel_q][IdxE] = reg16_data_i[7:0];
        end
        3'd2: begin
          rf_d[gp_sel_q][IdxH] = reg16_data_i[15:8];
          rf_d[gp_sel_q][IdxL] = reg16_data_i[7:0];
        end
        3'd3: sp_d = reg16_data_i;
        3'd4: pc_d = reg16_data_i;
        3'd5: if (ENABLE_INDEX) ix_d = reg16_data_i;
        3'd6: if (ENABLE_INDEX) iy_d = reg16_data_i;
        3'd7: begin
          rf_d[af_sel_q][IdxA] = reg16_data_i[15:8];
          rf_d[af_sel_q][IdxF] = reg16_data_i[7:0];
        end
      endcase
    end

    if (ENABLE_SHADOW) begin
      if (exx_i)   gp_sel_d = ~gp_sel_q;
      if (ex_af_i) af_sel_d = ~af_sel_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          rf_q[b][r] <= '0;
        end
      end
      ix_q     <= '0;
      iy_q     <= '0;
      pc_q     <= PC_RESET;
      sp_q     <= SP_RESET;
      af_sel_q <= 1'b0;
      gp_sel_q <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      af_sel_q <= af_sel_d;
      gp_sel_q <= gp_sel_d;
    end
  end

  assign a_o  = rf_q[af_sel_q][IdxA];
  assign f_o  = rf_q[af_sel_q][IdxF];
  assign b_o  = rf_q[gp_sel_q][IdxB];
  assign c_o  = rf_q[gp_sel_q][IdxC];
  assign d_o  = rf_q[gp_sel_q][IdxD];
  assign e_o  = rf_q[gp_sel_q][IdxE];
  assign h_o  = rf_q[gp_sel_q][IdxH];
  assign l_o  = rf_q[gp_sel_q][IdxL];
  assign ix_o = ENABLE_INDEX ? ix_q : 16'h0000;
  assign iy_o = ENABLE_INDEX ? iy_q : 16'h0000;
  assign pc_o = pc_q;
  assign sp_o = sp_q;

endmodule

// File: tb/tb_z80_regfile_banked.sv
module tb_z80_regfile_banked;

  typedef struct {
    logic        rst;
    logic        r8we;
    logic [2:0]  r8dst;
    logic [7:0]  r8d;
    logic        r16we;
    logic [2:0]  r16dst;
    logic [15:0] r16d;
    logic        fwe;
    logic [7:0]  fl;
    logic        exx;
    logic        exaf;
    logic        exdehl;
    logic        pcinc;
    logic [1:0]  spop;
  } in_t;

  typedef struct {
    in_t         i;
    int          dut;
    int          sel;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    int          dut;
    int          sel;
    logic [15:0] exp;
    string       nm;
  } sb_t;

  localparam int SA = 0, SB = 1, SF = 7, SIX = 8, SIY = 9, SPC = 10, SSP = 11;
  localparam int SBC = 12, SDE = 13, SHL = 14, SAF = 15;

  logic        clk = 1'b0;
  logic        reset, reg8_we, reg16_we, flags_we, exx, ex_af, ex_de_hl, pc_inc;
  logic [2:0]  reg8_dst, reg16_dst;
  logic [7:0]  reg8_data, flags;
  logic [15:0] reg16_data;
  logic [1:0]  sp_op;

  logic [7:0]  a1, b1, c1, d1, e1, h1, l1, f1, a2, b2, c2, d2, e2, h2, l2, f2;
  logic [15:0] ix1, iy1, pc1, sp1, ix2, iy2, pc2, sp2;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  z80_regfile_banked u_dut (
    .clk_i(clk), .reset_i(reset), .reg8_we_i(reg8_we), .reg8_dst_i(reg8_dst),
    .reg8_data_i(reg8_data), .reg16_we_i(reg16_we), .reg16_dst_i(reg16_dst),
    .reg16_data_i(reg16_data), .flags_we_i(flags_we), .flags_i(flags), .exx_i(exx),
    .ex_af_i(ex_af), .ex_de_hl_i(ex_de_hl), .pc_inc_i(pc_inc), .sp_op_i(sp_op),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .e_o(e1), .h_o(h1), .l_o(l1), .f_o(f1),
    .ix_o(ix1), .iy_o(iy1), .pc_o(pc1), .sp_o(sp1)
  );

  z80_regfile_banked #(
    .ENABLE_SHADOW(1'b0),
    .ENABLE_INDEX (1'b0)
  ) u_dut_min (
    .clk_i(clk), .reset_i(reset), .reg8_we_i(reg8_we), .reg8_dst_i(reg8_dst),
    .reg8_data_i(reg8_data), .reg16_we_i(reg16_we), .reg16_dst_i(reg16_dst),
    .reg16_data_i(reg16_data), .flags_we_i(flags_we), .flags_i(flags), .exx_i(exx),
    .ex_af_i(ex_af), .ex_de_hl_i(ex_de_hl), .pc_inc_i(pc_inc), .sp_op_i(sp_op),
    .a_o(a2), .b_o(b2), .c_o(c2), .d_o(d2), .e_o(e2), .h_o(h2), .l_o(l2), .f_o(f2),
    .ix_o(ix2), .iy_o(iy2), .pc_o(pc2), .sp_o(sp2)
  );

  function automatic logic [15:0] get(input int dut, input int sel);
    logic [7:0] a, b, c, d, e, h, l, f;
    logic [15:0] ix, iy, pc, sp;
    if (dut == 1) begin
      a = a1; b = b1; c = c1; d = d1; e = e1; h = h1; l = l1; f = f1;
      ix = ix1; iy = iy1; pc = pc1; sp = sp1;
    end else begin
      a = a2; b = b2; c = c2; d = d2; e = e2; h = h2; l = l2; f = f2;
      ix = ix2; iy = iy2; pc = pc2; sp = sp2;
    end
    case (sel)
      SA:      return {8'h00, a};
      SB:      return {8'h00, b};
      SF:      return {8'h00, f};
      SIX:     return ix;
      SIY:     return iy;
      SPC:     return pc;
      SSP:     return sp;
      SBC:     return {b, c};
      SDE:     return {d, e};
      SHL:     return {h, l};
      SAF:     return {a, f};
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic in_t nop();
    in_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic in_t r8(input logic [2:0] dst, input logic [7:0] d);
    in_t t;
    t = nop();
    t.r8we = 1'b1; t.r8dst = dst; t.r8d = d;
    return t;
  endfunction

  function automatic in_t r16(input logic [2:0] dst, input logic [15:0] d);
    in_t t;
    t = nop();
    t.r16we = 1'b1; t.r16dst = dst; t.r16d = d;
    return t;
  endfunction

  task automatic add(input in_t t, input int dut, input int sel, input logic [15:0] exp,
                     input string nm);
    vec_t v;
    v.i = t; v.dut = dut; v.sel = sel; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic check_one();
    sb_t         e;
    logic [15:0] act;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e   = sbq.pop_front();
      act = get(e.dut, e.sel);
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h required %h", e.nm, act, e.exp);
      end
    end
  endtask

  // Drive on the falling edge, let the rising edge update, sample 1 ns later.
  task automatic step(input vec_t v);
    sb_t e;
    reset = v.i.rst; reg8_we = v.i.r8we; reg8_dst = v.i.r8dst; reg8_data = v.i.r8d;
    reg16_we = v.i.r16we; reg16_dst = v.i.r16dst; reg16_data = v.i.r16d;
    flags_we = v.i.fwe; flags = v.i.fl; exx = v.i.exx; ex_af = v.i.exaf;
    ex_de_hl = v.i.exdehl; pc_inc = v.i.pcinc; sp_op = v.i.spop;
    e.dut = v.dut; e.sel = v.sel; e.exp = v.exp; e.nm = v.nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_one();
    @(negedge clk);
  endtask

  initial begin
    in_t t;
    step('{nop(), 1, SAF, 16'h0000, "pre"});  // flush X from power-up, result discarded below
    checks = 0;
    errors = 0;

    t = nop(); t.rst = 1'b1;   add(t,       1, SSP, 16'hFFFE, "reset_sp");
    add(nop(),                              1, SPC, 16'h0000, "reset_pc");
    add(nop(),                              1, SAF, 16'h0000, "reset_af");
    add(r16(3'd0, 16'hABCD),                1, SBC, 16'hABCD, "w_bc");
    add(r16(3'd1, 16'h1234),                1, SDE, 16'h1234, "w_de");
    add(r16(3'd2, 16'h5678),                1, SHL, 16'h5678, "w_hl");
    t = nop(); t.exx = 1'b1;   add(t,       1, SBC, 16'h0000, "exx1_bc");
    add(nop(),                              1, SDE, 16'h0000, "exx1_de");
    add(nop(),                              1, SHL, 16'h0000, "exx1_hl");
    t = nop(); t.exx = 1'b1;   add(t,       1, SBC, 16'hABCD, "exx2_bc");
    add(nop(),                              1, SDE, 16'h1234, "exx2_de");
    add(nop(),                              1, SHL, 16'h5678, "exx2_hl");
    add(r16(3'd7, 16'h12F0),                1, SAF, 16'h12F0, "w_af");
    t = nop(); t.exaf = 1'b1;  add(t,       1, SAF, 16'h0000, "exaf1");
    add(r8(3'd0, 8'h77),                    1, SA,  16'h0077, "w_a_shadow");
    t = nop(); t.exaf = 1'b1;  add(t,       1, SAF, 16'h12F0, "exaf2");
    t = r8(3'd3, 8'h55); t.exdehl = 1'b1; add(t, 1, SDE, 16'h5578, "exdehl_de");
    add(nop(),                              1, SHL, 16'h1234, "exdehl_hl");
    add(r16(3'd4, 16'hFFFF),                1, SPC, 16'hFFFF, "w_pc");
    t = nop(); t.pcinc = 1'b1; add(t,       1, SPC, 16'h0000, "pc_wrap");
    add(r16(3'd3, 16'h0001),                1, SSP, 16'h0001, "w_sp");
    t = nop(); t.spop = 2'b01; add(t,       1, SSP, 16'hFFFF, "sp_dec_wrap");
    t = nop(); t.spop = 2'b10; add(t,       1, SSP, 16'h0001, "sp_inc");
    t = r16(3'd3, 16'h8000); t.spop = 2'b01; add(t, 1, SSP, 16'h8000, "sp_w_over_op");
    t = nop(); t.spop = 2'b11; add(t,       1, SSP, 16'h8000, "sp_reserved");
    t = r16(3'd4, 16'h1234); t.pcinc = 1'b1; add(t, 1, SPC, 16'h1234, "pc_w_over_inc");
    t = nop(); t.pcinc = 1'b1; add(t,       1, SPC, 16'h1235, "pc_inc");
    add(r16(3'd3, 16'hFFFE),                1, SSP, 16'hFFFE, "w_sp2");
    t = nop(); t.spop = 2'b10; add(t,       1, SSP, 16'h0000, "sp_inc_wrap");
    t = r8(3'd1, 8'h11); t.exx = 1'b1; add(t, 1, SB, 16'h0000, "w_b_exx");
    t = nop(); t.exx = 1'b1;   add(t,       1, SB,  16'h0011, "w_b_back");
    t = r8(3'd7, 8'h0F); t.fwe = 1'b1; t.fl = 8'hF0; add(t, 1, SF, 16'h000F, "r8_over_flags");
    t = nop(); t.fwe = 1'b1; t.fl = 8'hF0; add(t, 1, SF, 16'h00F0, "flags");
    t = r16(3'd7, 16'hAABB); t.r8we = 1'b1; t.r8dst = 3'd0; t.r8d = 8'h11;
    t.fwe = 1'b1; t.fl = 8'h22; add(t,      1, SAF, 16'hAABB, "r16_af_prio");
    add(r16(3'd5, 16'hBEEF),                1, SIX, 16'hBEEF, "w_ix");
    add(r16(3'd6, 16'hCAFE),                1, SIY, 16'hCAFE, "w_iy");
    // Bank 0 now holds DE=5578 HL=1234: swap in old bank, then toggle to bank 1.
    t = nop(); t.exdehl = 1'b1; t.exx = 1'b1; add(t, 1, SDE, 16'h0000, "exdehl_exx_de");
    t = nop(); t.exx = 1'b1;   add(t,       1, SHL, 16'h5578, "exdehl_exx_hl");
    add(nop(),                              1, SDE, 16'h1234, "exdehl_exx_de0");
    t = r16(3'd1, 16'h4321); t.exx = 1'b1; add(t, 1, SDE, 16'h0000, "w_de_exx");
    t = nop(); t.exx = 1'b1;   add(t,       1, SDE, 16'h4321, "w_de_back");

    foreach (tbl[k]) step(tbl[k]);

    // Reset mid-sequence with pending exchange and write.
    t = r16(3'd0, 16'h1111); t.rst = 1'b1; t.exx = 1'b1; t.exaf = 1'b1;
    step('{t, 1, SBC, 16'h0000, "rst_mid_bc"});
    step('{nop(), 1, SSP, 16'hFFFE, "rst_mid_sp"});
    step('{nop(), 1, SIX, 16'h0000, "rst_mid_ix"});
    step('{nop(), 1, SAF, 16'h0000, "rst_mid_af"});
    t = nop(); t.pcinc = 1'b1;
    step('{t, 1, SPC, 16'h0001, "rst_mid_pc"});

    // Reduced configuration: no shadow set, no index registers.
    t = nop(); t.rst = 1'b1;
    step('{t, 2, SPC, 16'h0000, "min_reset_pc"});
    step('{r16(3'd0, 16'hABCD), 2, SBC, 16'hABCD, "min_w_bc"});
    t = nop(); t.exx = 1'b1;
    step('{t, 2, SBC, 16'hABCD, "min_exx_ignored"});
    step('{r16(3'd7, 16'h12F0), 2, SAF, 16'h12F0, "min_w_af"});
    t = nop(); t.exaf = 1'b1;
    step('{t, 2, SAF, 16'h12F0, "min_exaf_ignored"});
    step('{r16(3'd5, 16'hBEEF), 2, SIX, 16'h0000, "min_ix_dropped"});
    step('{r16(3'd6, 16'hCAFE), 2, SIY, 16'h0000, "min_iy_dropped"});
    step('{r16(3'd1, 16'h1234), 2, SDE, 16'h1234, "min_w_de"});
    step('{r16(3'd2, 16'h5678), 2, SHL, 16'h5678, "min_w_hl"});
    t = nop(); t.exdehl = 1'b1;
    step('{t, 2, SDE, 16'h5678, "min_exdehl"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
